// File: rtl/mips_core_pkg.sv
// Shared definitions for the mips_core checkpoint controller.
package mips_core_pkg;

  localparam int SNAP_DEPTH     = 4;
  localparam int SNAP_TAG_WIDTH = $clog2(SNAP_DEPTH);
  localparam int NUM_REGS       = 32;

  // Recovery FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECOVER   = 2'd1,
    WAIT_DONE = 2'd2
  } snap_state_t;

  typedef logic [SNAP_TAG_WIDTH-1:0] snap_tag_t;

endpackage

// File: rtl/snapshot_buffer.sv
// Checkpoint storage: DEPTH entries, each holding a full 32-register copy.
// One synchronous write port, one asynchronous read port.
module snapshot_buffer
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = SNAP_DEPTH,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [TAG_WIDTH-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata [NUM_REGS],
  input  logic [TAG_WIDTH-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata [NUM_REGS]
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH][NUM_REGS];

  // Write a whole register vector into the addressed entry.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i_waddr][i] <= i_wdata[i];
      end
    end
  end

  // Asynchronous read of the addressed entry.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      o_rdata[i] = r_mem[i_raddr][i];
    end
  end

endmodule

// File: rtl/reg_snapshot_ctrl.sv
// Register-file checkpoint controller: captures a copy of the architectural
// registers per predicted branch, retires them oldest-first and restores
// reg_file on a misprediction while stalling the front end.
//
// Handshakes: take_snapshot is accepted only in a cycle where snap_ready is
// high (otherwise dropped, producer must stall); resolve_valid is accepted in
// IDLE only; recover_snapshot is a one-cycle pulse and busy stays high until
// the cycle after recover_done is seen in WAIT_DONE.
module reg_snapshot_ctrl
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = SNAP_DEPTH,
  parameter int TAG_WIDTH  = $clog2(DEPTH),
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  take_snapshot,
  input  logic [DATA_WIDTH-1:0] regs_in [NUM_REGS],
  input  logic                  wb_uses_rw,
  input  logic [4:0]            wb_rw_addr,
  input  logic [DATA_WIDTH-1:0] wb_rw_data,
  output logic                  snap_ready,
  output logic [TAG_WIDTH-1:0]  snap_tag,
  input  logic                  resolve_valid,
  input  logic [TAG_WIDTH-1:0]  resolve_tag,
  input  logic                  resolve_mispredict,
  output logic                  recover_snapshot,
  output logic [DATA_WIDTH-1:0] regs_snapshot [NUM_REGS],
  input  logic                  recover_done,
  output logic                  busy,
  output logic                  order_err,
  output snap_state_t           dbg_state,
  output logic [TAG_WIDTH:0]    dbg_count
);

  localparam logic [TAG_WIDTH:0] CNT_FULL = (TAG_WIDTH + 1)'(DEPTH);

  snap_state_t           r_state;
  snap_state_t           w_state_next;
  logic [TAG_WIDTH-1:0]  r_head;
  logic [TAG_WIDTH-1:0]  r_tail;
  logic [TAG_WIDTH:0]    r_count;
  logic                  r_order_err;
  logic [DATA_WIDTH-1:0] r_regs_snapshot [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_merged        [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rd_data       [NUM_REGS];

  logic w_idle;
  logic w_snap_ready;
  logic w_res_legal;
  logic w_res_illegal;
  logic w_mispredict;
  logic w_correct;
  logic w_we;

  assign w_idle        = (r_state == IDLE);
  // Readiness is from registers only; a same-cycle resolve does not free a slot.
  assign w_snap_ready  = w_idle && (r_count < CNT_FULL);
  assign w_res_legal   = w_idle && resolve_valid && (resolve_tag == r_tail) &&
                         (r_count != '0);
  assign w_res_illegal = w_idle && resolve_valid && !w_res_legal;
  assign w_mispredict  = w_res_legal && resolve_mispredict;
  assign w_correct     = w_res_legal && !resolve_mispredict;
  // A take alongside a mispredict belongs to a squashed younger instruction.
  assign w_we          = take_snapshot && w_snap_ready && !w_mispredict;

  // Bypass merge: the write-back landing this cycle is part of the checkpoint.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_merged[i] = regs_in[i];
      if (wb_uses_rw && (wb_rw_addr != 5'd0) && (wb_rw_addr == i[4:0])) begin
        w_merged[i] = wb_rw_data;
      end
    end
  end

  snapshot_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_buffer (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_head),
    .i_wdata (w_merged),
    .i_raddr (r_tail),
    .o_rdata (w_rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and recovery outputs.
  always_comb begin
    w_state_next     = r_state;
    recover_snapshot = 1'b0;
    busy             = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_mispredict) w_state_next = RECOVER;
      end
      RECOVER: begin
        recover_snapshot = 1'b1;
        busy             = 1'b1;
        w_state_next     = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (recover_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pointers, occupancy, recovery data latch and sticky ordering error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_order_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs_snapshot[i] <= '0;
    end else begin
      if (w_mispredict) begin
        // Oldest checkpoint is restored; everything younger is squashed.
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        for (int i = 0; i < NUM_REGS; i++) r_regs_snapshot[i] <= w_rd_data[i];
      end else begin
        if (w_we)      r_head <= r_head + 1'b1;
        if (w_correct) r_tail <= r_tail + 1'b1;
        case ({w_we, w_correct})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      if (w_res_illegal) r_order_err <= 1'b1;
    end
  end

  assign snap_ready    = w_snap_ready;
  assign snap_tag      = r_head;
  assign order_err     = r_order_err;
  assign regs_snapshot = r_regs_snapshot;
  assign dbg_state     = r_state;
  assign dbg_count     = r_count;

endmodule

// File: tb/tb_reg_snapshot_ctrl.sv
// Directed bench for reg_snapshot_ctrl with a reference model and an
// expected-recovery scoreboard.
module tb_reg_snapshot_ctrl;

  localparam int DW = 32;
  localparam int VW = 32 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          take_snapshot;
  logic [DW-1:0] regs_in [32];
  logic          wb_uses_rw;
  logic [4:0]    wb_rw_addr;
  logic [DW-1:0] wb_rw_data;
  logic          snap_ready;
  logic [1:0]    snap_tag;
  logic          resolve_valid;
  logic [1:0]    resolve_tag;
  logic          resolve_mispredict;
  logic          recover_snapshot;
  logic [DW-1:0] regs_snapshot [32];
  logic          recover_done;
  logic          busy;
  logic          order_err;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_count;

  reg_snapshot_ctrl #(.DEPTH(4), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .take_snapshot      (take_snapshot),
    .regs_in            (regs_in),
    .wb_uses_rw         (wb_uses_rw),
    .wb_rw_addr         (wb_rw_addr),
    .wb_rw_data         (wb_rw_data),
    .snap_ready         (snap_ready),
    .snap_tag           (snap_tag),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .recover_snapshot   (recover_snapshot),
    .regs_snapshot      (regs_snapshot),
    .recover_done       (recover_done),
    .busy               (busy),
    .order_err          (order_err),
    .dbg_state          (dbg_state),
    .dbg_count          (dbg_count)
  );

  // ---------------- model / scoreboard ----------------
  int            n_vec = 0;
  int            n_err = 0;
  int            n_pulse = 0;
  int            m_st, m_head, m_tail, m_count;
  bit            m_err;
  logic [VW-1:0] m_snap;
  logic [VW-1:0] m_mem [4];
  logic [VW-1:0] exp_q [$];

  function automatic logic [VW-1:0] pack(input logic [DW-1:0] a [32]);
    logic [VW-1:0] v;
    for (int i = 0; i < 32; i++) v[i*DW +: DW] = a[i];
    return v;
  endfunction

  // Checkpoint content implied by the current regs_in and write-back inputs.
  function automatic logic [VW-1:0] merged();
    logic [VW-1:0] v;
    for (int i = 0; i < 32; i++) begin
      if (wb_uses_rw && (wb_rw_addr == 5'(i)) && (i != 0)) v[i*DW +: DW] = wb_rw_data;
      else v[i*DW +: DW] = regs_in[i];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("snap_ready", VW'(snap_ready), VW'(m_st == 0 && m_count < 4));
    chk("snap_tag", VW'(snap_tag), VW'(m_head));
    chk("busy", VW'(busy), VW'(m_st != 0));
    chk("recover_snapshot", VW'(recover_snapshot), VW'(m_st == 1));
    chk("order_err", VW'(order_err), VW'(m_err));
    chk("count", VW'(dbg_count), VW'(m_count));
    chk("state", VW'(dbg_state), VW'(m_st));
    chk("regs_snapshot", pack(regs_snapshot), m_snap);
  endtask

  // Recovery pulses are popped against the scoreboard.
  always @(negedge clk) begin
    if (recover_snapshot === 1'b1) begin
      n_pulse++;
      n_vec++;
      assert (exp_q.size() > 0)
      else begin
        n_err++;
        $error("FAIL sb_unexpected_recover: observed pulse expected none");
      end
      if (exp_q.size() > 0) chk("sb_regs_snapshot", pack(regs_snapshot), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs();
    for (int i = 0; i < 32; i++) regs_in[i] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    take_snapshot = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    recover_done = 1'b0; wb_uses_rw = 1'b0;
    tick();
    rst = 1'b0;
    m_st = 0; m_head = 0; m_tail = 0; m_count = 0; m_err = 1'b0; m_snap = '0;
    check_all();
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic apply(input bit tk, input bit rv, input int rt, input bit mp, input bit dn);
    bit idle, ready, legal, mis, cor, we;
    take_snapshot = tk; resolve_valid = rv; resolve_tag = rt[1:0];
    resolve_mispredict = mp; recover_done = dn;
    idle  = (m_st == 0);
    ready = idle && (m_count < 4);
    legal = idle && rv && (rt == m_tail) && (m_count > 0);
    mis   = legal && mp;
    cor   = legal && !mp;
    we    = tk && ready && !mis;
    if (we) m_mem[m_head] = merged();
    if (idle && rv && !legal) m_err = 1'b1;
    if (mis) begin
      m_snap = m_mem[m_tail];
      exp_q.push_back(m_mem[m_tail]);
      m_head = 0; m_tail = 0; m_count = 0; m_st = 1;
    end else if (idle) begin
      if (we)  m_head = (m_head + 1) % 4;
      if (cor) m_tail = (m_tail + 1) % 4;
      m_count = m_count + int'(we) - int'(cor);
    end else if (m_st == 1) begin
      m_st = 2;
    end else if (dn) begin
      m_st = 0;
    end
    tick();
    take_snapshot = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    recover_done = 1'b0; wb_uses_rw = 1'b0;
    check_all();
  endtask

  // Called in the RECOVER cycle; returns the number of busy cycles observed.
  task automatic finish_recovery(input int hold, output int bc);
    bc = 0;
    if (busy) bc++;
    apply(0, 0, 0, 0, 0);
    for (int k = 0; k < hold; k++) begin
      if (busy) bc++;
      apply(0, 0, 0, 0, 0);
    end
    if (busy) bc++;
    apply(0, 0, 0, 0, 1);
    if (busy) bc++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bc;
    int p0;
    rst = 1'b1; take_snapshot = 1'b0; resolve_valid = 1'b0; resolve_tag = '0;
    resolve_mispredict = 1'b0; recover_done = 1'b0; wb_uses_rw = 1'b0;
    wb_rw_addr = '0; wb_rw_data = '0;
    for (int i = 0; i < 32; i++) regs_in[i] = '0;
    for (int e = 0; e < 4; e++) m_mem[e] = '0;
    do_reset();

    // Bypass merge onto register 5.
    set_regs(); regs_in[5] = 32'h11;
    wb_uses_rw = 1'b1; wb_rw_addr = 5'd5; wb_rw_data = 32'hAA;
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 1, 0);
    chk("bypass_r5", VW'(regs_snapshot[5]), VW'(32'hAA));
    finish_recovery(0, bc);

    // Write-back to register 0 must not be merged.
    set_regs(); regs_in[0] = 32'h22;
    wb_uses_rw = 1'b1; wb_rw_addr = 5'd0; wb_rw_data = 32'hBB;
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 1, 0);
    chk("bypass_r0", VW'(regs_snapshot[0]), VW'(32'h22));
    finish_recovery(0, bc);

    // Fill, overflow drop, drain, wrap.
    for (int k = 0; k < 4; k++) begin set_regs(); apply(1, 0, 0, 0, 0); end
    chk("full_not_ready", VW'(snap_ready), VW'(1'b0));
    set_regs(); apply(1, 0, 0, 0, 0);
    chk("full_drop_count", VW'(dbg_count), VW'(3'd4));
    for (int k = 0; k < 4; k++) apply(0, 1, k, 0, 0);
    chk("drained_count", VW'(dbg_count), VW'(3'd0));
    chk("wrap_tag0", VW'(snap_tag), VW'(2'd0));
    set_regs(); apply(1, 0, 0, 0, 0);
    chk("wrap_tag1", VW'(snap_tag), VW'(2'd1));
    set_regs(); apply(1, 0, 0, 0, 0);

    // Take plus correct resolve at count 2, then take plus mispredict.
    set_regs(); apply(1, 1, 0, 0, 0);
    chk("simul_count", VW'(dbg_count), VW'(3'd2));
    set_regs(); apply(1, 1, 1, 1, 0);
    finish_recovery(0, bc);
    chk("simul_mis_count", VW'(dbg_count), VW'(3'd0));

    // Mispredict flush of three checkpoints.
    for (int v = 1; v <= 3; v++) begin
      set_regs(); regs_in[1] = DW'(v); apply(1, 0, 0, 0, 0);
    end
    p0 = n_pulse;
    apply(0, 1, 0, 1, 0);
    chk("flush_r1", VW'(regs_snapshot[1]), VW'(32'd1));
    finish_recovery(0, bc);
    chk("flush_busy_cycles", VW'(bc), VW'(2));
    chk("flush_one_pulse", VW'(n_pulse - p0), VW'(1));
    chk("flush_tag", VW'(snap_tag), VW'(2'd0));

    // Illegal resolves: wrong tag, then empty buffer.
    set_regs(); apply(1, 0, 0, 0, 0);
    apply(0, 1, 1, 0, 0);
    chk("illegal_tag_err", VW'(order_err), VW'(1'b1));
    chk("illegal_tag_count", VW'(dbg_count), VW'(3'd1));
    do_reset();
    apply(0, 1, 0, 0, 0);
    chk("illegal_empty_err", VW'(order_err), VW'(1'b1));

    // Reset during WAIT_DONE.
    do_reset();
    set_regs(); apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 1, 0);
    apply(0, 0, 0, 0, 0);
    chk("in_wait_done", VW'(dbg_state), VW'(2'd2));
    do_reset();
    chk("rst_recover_low", VW'(recover_snapshot), VW'(1'b0));
    apply(0, 0, 0, 0, 0);

    // Late recover_done: busy holds until the cycle after it arrives.
    set_regs(); apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 1, 0);
    finish_recovery(5, bc);
    chk("late_done_busy_cycles", VW'(bc), VW'(7));

    apply(0, 0, 0, 0, 0);
    chk("sb_queue_empty", VW'(exp_q.size()), VW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
